// File: rtl/store_queue_p_pkg.sv
// Shared types for the store queue: entry, load-lookup and forward-result packets.
// The default queue depth (as log2) also lives here.
package store_queue_p_pkg;
    localparam int SQ_LSQ_LOG = 3;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  usebytes;
        logic [31:0] data;
    } SQ_ENTRY_PACKET;

    typedef struct packed {
        logic [31:0]           addr;
        logic [SQ_LSQ_LOG-1:0] tail_pos;
    } LOAD_SQ_PACKET;

    typedef struct packed {
        logic        stall;
        logic [3:0]  usebytes;
        logic [31:0] data;
    } SQ_LOAD_PACKET;
endpackage

// File: rtl/store_queue_p_if.sv
// Dispatch, execute, retire, squash, load-lookup and debug signals of the store queue.
// The slave modport is the queue side; the master modport is the pipeline side.
interface store_queue_p_if
    import store_queue_p_pkg::*;
#(
    parameter int LSQ_LOG = SQ_LSQ_LOG,
    parameter int DISP_W  = 3,
    parameter int EXE_W   = 3,
    parameter int RET_W   = 3,
    parameter int LD_W    = 2
);
    logic [DISP_W-1:0]               dispatch_req;
    logic [DISP_W-1:0]               dispatch;
    logic [DISP_W-1:0]               stall;
    logic [DISP_W-1:0][LSQ_LOG-1:0]  tail_pos;
    logic [EXE_W-1:0]                exe_valid;
    SQ_ENTRY_PACKET [EXE_W-1:0]      exe_store;
    logic [EXE_W-1:0][LSQ_LOG-1:0]   exe_idx;
    LOAD_SQ_PACKET [LD_W-1:0]        load_lookup;
    SQ_LOAD_PACKET [LD_W-1:0]        load_forward;
    logic [RET_W-1:0]                retire;
    SQ_ENTRY_PACKET [RET_W-1:0]      cache_wb;
    logic                            squash;
    logic [LSQ_LOG-1:0]              squash_tail;
    logic [LSQ_LOG-1:0]              head_dis;
    logic [LSQ_LOG-1:0]              tail_dis;
    logic [LSQ_LOG:0]                filled_num_dis;

    modport slave (
        input  dispatch_req, dispatch, exe_valid, exe_store, exe_idx,
               load_lookup, retire, squash, squash_tail,
        output stall, tail_pos, load_forward, cache_wb,
               head_dis, tail_dis, filled_num_dis
    );

    modport master (
        output dispatch_req, dispatch, exe_valid, exe_store, exe_idx,
               load_lookup, retire, squash, squash_tail,
        input  stall, tail_pos, load_forward, cache_wb,
               head_dis, tail_dis, filled_num_dis
    );
endinterface

// File: rtl/store_queue_p_fwd.sv
// One load port's store-to-load forwarding: selects stores older than the load,
// stalls on any unresolved one, else merges bytes from the youngest matching store.
module sq_fwd_unit
    import store_queue_p_pkg::*;
#(
    parameter int LSQ_LOG = SQ_LSQ_LOG
) (
    input  SQ_ENTRY_PACKET [2**LSQ_LOG-1:0] entry_i,
    input  logic [2**LSQ_LOG-1:0]           ready_i,
    input  logic [LSQ_LOG-1:0]              head_i,
    input  LOAD_SQ_PACKET                   lookup_i,
    output SQ_LOAD_PACKET                   forward_o
);
    localparam int DEPTH = 2**LSQ_LOG;
    typedef logic [LSQ_LOG-1:0] idx_t;

    idx_t          span;
    idx_t          e;
    SQ_LOAD_PACKET fwd;

    // Walk oldest to youngest so later matches overwrite earlier ones per byte.
    always_comb begin
        span = idx_t'(idx_t'(lookup_i.tail_pos) - head_i);
        e    = '0;
        fwd  = '0;
        for (int off = 0; off < DEPTH; off++) begin
            e = idx_t'(head_i + off);
            if (off < int'(span)) begin
                if (!ready_i[e]) fwd.stall = 1'b1;
                if (entry_i[e].addr[31:2] == lookup_i.addr[31:2]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (entry_i[e].usebytes[b]) begin
                            fwd.usebytes[b]     = 1'b1;
                            fwd.data[8*b +: 8] = entry_i[e].data[8*b +: 8];
                        end
                    end
                end
            end
        end
        if (fwd.stall) begin
            fwd.usebytes = '0;
            fwd.data     = '0;
        end
        forward_o = fwd;
    end
endmodule

// File: rtl/store_queue_p.sv
// Circular store queue: multi-lane dispatch/execute/retire, squash rollback of the
// tail, and per-load-port forwarding from registered state.
module store_queue_p
    import store_queue_p_pkg::*;
#(
    parameter int LSQ_LOG = SQ_LSQ_LOG,
    parameter int DISP_W  = 3,
    parameter int EXE_W   = 3,
    parameter int RET_W   = 3,
    parameter int LD_W    = 2
) (
    input logic            clock,
    input logic            reset,
    store_queue_p_if.slave bus
);
    localparam int DEPTH = 2**LSQ_LOG;
    typedef logic [LSQ_LOG-1:0] idx_t;

    SQ_ENTRY_PACKET [DEPTH-1:0]     entry_q, entry_d;
    logic [DEPTH-1:0]               ready_q, ready_d;
    idx_t                           head_q, head_d, tail_q, tail_d;
    logic [LSQ_LOG:0]               count_q, count_d;
    logic [LSQ_LOG:0]               n_disp, n_ret;
    logic [DISP_W-1:0][LSQ_LOG-1:0] lane_pos;

    always_comb begin
        n_disp = '0;
        for (int i = 0; i < DISP_W; i++) begin
            lane_pos[i] = idx_t'(tail_q + n_disp);
            if (bus.dispatch[i]) n_disp = n_disp + 1'b1;
        end
        n_ret = '0;
        for (int k = 0; k < RET_W; k++) begin
            if (bus.retire[k]) n_ret = n_ret + 1'b1;
        end
        head_d  = idx_t'(head_q + n_ret);
        entry_d = entry_q;
        ready_d = ready_q;
        // A squash rewinds the tail; any dispatch in the same cycle is dropped.
        if (bus.squash) begin
            tail_d  = bus.squash_tail;
            count_d = {1'b0, idx_t'(bus.squash_tail - head_d)};
        end else begin
            tail_d  = idx_t'(tail_q + n_disp);
            count_d = count_q + n_disp - n_ret;
            for (int i = 0; i < DISP_W; i++) begin
                if (bus.dispatch[i]) begin
                    entry_d[lane_pos[i]] = '0;
                    ready_d[lane_pos[i]] = 1'b0;
                end
            end
        end
        for (int j = 0; j < EXE_W; j++) begin
            if (bus.exe_valid[j]) begin
                entry_d[bus.exe_idx[j]] = bus.exe_store[j];
                ready_d[bus.exe_idx[j]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            entry_q <= '0;
            ready_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            entry_q <= entry_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        for (int i = 0; i < DISP_W; i++) begin
            bus.stall[i] = (i >= DEPTH - int'(count_q));
        end
        for (int k = 0; k < RET_W; k++) begin
            bus.cache_wb[k] = entry_q[idx_t'(head_q + k)];
        end
    end

    assign bus.tail_pos       = lane_pos;
    assign bus.head_dis       = head_q;
    assign bus.tail_dis       = tail_q;
    assign bus.filled_num_dis = count_q;

    for (genvar p = 0; p < LD_W; p++) begin : g_fwd
        sq_fwd_unit #(.LSQ_LOG(LSQ_LOG)) u_fwd (
            .entry_i   (entry_q),
            .ready_i   (ready_q),
            .head_i    (head_q),
            .lookup_i  (bus.load_lookup[p]),
            .forward_o (bus.load_forward[p])
        );
    end

    // Retire must be a low-bit prefix and may only drain resolved stores.
    always @(posedge clock) begin
        if (reset) begin
            assert ((bus.retire & (bus.retire + 1'b1)) == '0)
                else $error("store_queue_p: non-prefix retire %b", bus.retire);
            for (int k = 0; k < RET_W; k++) begin
                assert (!bus.retire[k] || ready_q[idx_t'(head_q + k)])
                    else $error("store_queue_p: retire of unresolved entry lane %0d", k);
            end
        end
    end
endmodule
